fb_dac_driver: RTL and testbench

- Sits directly downstream of the DSP feedback calculation stage and drives the feedback DAC.
- Takes the 15-bit signed correction word, its overflow flag, the fb_cond sample window and the dac_clk strobe, and produces a 14-bit offset-binary DAC code and a DAC write strobe.
- Applies a programmable offset, symmetric clamping, overflow substitution and an overflow-run trip interlock.
- Keeps saturating overflow and clamp statistics for readout.

---
 rtl/fb_dac_driver_if.sv | 34 +++
 rtl/fb_dac_driver.sv | 182 ++++++++++++++++++
 tb/tb_fb_dac_driver.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_dac_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_dac_driver_if
// Summary  : Calc-stage-to-DAC bundle: correction word, flags, strobes, code.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_dac_driver_if;
    logic signed [14:0] pout;
    logic               dsp_oflow;
    logic               fb_cond;
    logic               dac_clk;
    logic        [13:0] dac_data;
    logic               dac_wr;

    // Calc-stage side: produces the correction, observes the DAC write.
    modport master (
        output pout,
        output dsp_oflow,
        output fb_cond,
        output dac_clk,
        input  dac_data,
        input  dac_wr
    );

    modport slave (
        input  pout,
        input  dsp_oflow,
        input  fb_cond,
        input  dac_clk,
        output dac_data,
        output dac_wr
    );
endinterface
`default_nettype wire

// File: rtl/fb_dac_driver.sv
`default_nettype none
// ============================================================================
// Module   : fb_dac_driver
// Summary  : Offset, clamp and overflow-trip stage driving the feedback DAC.
// Revision : 1.0 - initial release
// ============================================================================
module fb_dac_driver #(
    parameter int LIMIT      = 8191,
    parameter int TRIP_COUNT = 4,
    parameter int MID        = 8192
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    fb_dac_driver_if.slave          bus,
    input  wire logic               store_strb,
    input  wire logic               fb_en,
    input  wire logic signed [12:0] dac_offset,
    input  wire logic               clr_stats,
    output logic                    tripped,
    output logic                    sat_flag,
    output logic             [15:0] oflow_cnt,
    output logic             [15:0] sat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_TRIPPED = 2'd2
    } state_t;

    localparam logic signed [16:0] LIM_POS  = 17'(LIMIT);
    localparam logic signed [16:0] LIM_NEG  = -LIM_POS;
    localparam logic        [13:0] MID_CODE = 14'(MID);
    localparam logic         [7:0] TRIP_CNT = 8'(TRIP_COUNT);

    state_t             state_q,     state_d;
    logic signed [14:0] p0_q,        p0_d;
    logic               of0_q,       of0_d;
    logic               v0_q,        v0_d;
    logic signed [16:0] sum1_q,      sum1_d;
    logic               v1_q,        v1_d;
    logic        [13:0] c2_q,        c2_d;
    logic               s2_q,        s2_d;
    logic               v2_q,        v2_d;
    logic        [13:0] dac_data_q,  dac_data_d;
    logic               dac_wr_q,    dac_wr_d;
    logic               sat_flag_q,  sat_flag_d;
    logic         [7:0] run_cnt_q,   run_cnt_d;
    logic        [15:0] oflow_cnt_q, oflow_cnt_d;
    logic        [15:0] sat_cnt_q,   sat_cnt_d;

    // Datapath: capture, offset add, clamp, offset-binary output.
    always_comb begin
        p0_d  = bus.pout;
        of0_d = bus.dsp_oflow;
        v0_d  = bus.fb_cond;

        // An overflowed word is replaced by zero so only the offset reaches the DAC.
        sum1_d = (of0_q ? 17'sd0 : {{2{p0_q[14]}}, p0_q})
               + {{4{dac_offset[12]}}, dac_offset};
        v1_d   = v0_q;

        c2_d = sum1_q[13:0];
        s2_d = 1'b0;
        if (sum1_q > LIM_POS) begin
            c2_d = LIM_POS[13:0];
            s2_d = 1'b1;
        end else if (sum1_q < LIM_NEG) begin
            c2_d = LIM_NEG[13:0];
            s2_d = 1'b1;
        end
        v2_d = v1_q;

        dac_data_d = dac_data_q;
        if (state_q != ST_ACTIVE) begin
            dac_data_d = MID_CODE;
        end else if (v2_q) begin
            dac_data_d = c2_q + MID_CODE;
        end

        sat_flag_d = v2_q & s2_q;
        dac_wr_d   = bus.dac_clk;
    end

    // Statistics and overflow-run tracking.
    always_comb begin
        oflow_cnt_d = oflow_cnt_q;
        if (clr_stats) begin
            oflow_cnt_d = 16'd0;
        end else if (v0_q && of0_q && (oflow_cnt_q != 16'hFFFF)) begin
            oflow_cnt_d = oflow_cnt_q + 16'd1;
        end

        sat_cnt_d = sat_cnt_q;
        if (clr_stats) begin
            sat_cnt_d = 16'd0;
        end else if (v2_q && s2_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end

        run_cnt_d = run_cnt_q;
        if (state_q != ST_ACTIVE) begin
            run_cnt_d = 8'd0;
        end else if (v0_q) begin
            if (!of0_q) begin
                run_cnt_d = 8'd0;
            end else if (run_cnt_q != 8'hFF) begin
                run_cnt_d = run_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (store_strb && fb_en) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // A completed overflow run wins over a stored-beam drop while enabled.
                if ((run_cnt_q >= TRIP_CNT) && fb_en) begin
                    state_d = ST_TRIPPED;
                end else if (!store_strb || !fb_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIPPED: begin
                if (!store_strb) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            p0_q        <= '0;
            of0_q       <= 1'b0;
            v0_q        <= 1'b0;
            sum1_q      <= '0;
            v1_q        <= 1'b0;
            c2_q        <= '0;
            s2_q        <= 1'b0;
            v2_q        <= 1'b0;
            dac_data_q  <= MID_CODE;
            dac_wr_q    <= 1'b0;
            sat_flag_q  <= 1'b0;
            run_cnt_q   <= '0;
            oflow_cnt_q <= '0;
            sat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            p0_q        <= p0_d;
            of0_q       <= of0_d;
            v0_q        <= v0_d;
            sum1_q      <= sum1_d;
            v1_q        <= v1_d;
            c2_q        <= c2_d;
            s2_q        <= s2_d;
            v2_q        <= v2_d;
            dac_data_q  <= dac_data_d;
            dac_wr_q    <= dac_wr_d;
            sat_flag_q  <= sat_flag_d;
            run_cnt_q   <= run_cnt_d;
            oflow_cnt_q <= oflow_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign bus.dac_data = dac_data_q;
    assign bus.dac_wr   = dac_wr_q;
    assign tripped      = (state_q == ST_TRIPPED);
    assign sat_flag     = sat_flag_q;
    assign oflow_cnt    = oflow_cnt_q;
    assign sat_cnt      = sat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_dac_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_dac_driver
// Summary  : Vector table plus scoreboard bench for fb_dac_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_dac_driver;

    localparam int LIMIT      = 8191;
    localparam int TRIP_COUNT = 4;
    localparam int MID        = 8192;

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b0;
    logic               store_strb = 1'b0;
    logic               fb_en      = 1'b0;
    logic               clr_stats  = 1'b0;
    logic signed [12:0] dac_offset = '0;
    logic               tripped;
    logic               sat_flag;
    logic        [15:0] oflow_cnt;
    logic        [15:0] sat_cnt;

    fb_dac_driver_if bus();

    fb_dac_driver #(
        .LIMIT      (LIMIT),
        .TRIP_COUNT (TRIP_COUNT),
        .MID        (MID)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .store_strb (store_strb),
        .fb_en      (fb_en),
        .dac_offset (dac_offset),
        .clr_stats  (clr_stats),
        .tripped    (tripped),
        .sat_flag   (sat_flag),
        .oflow_cnt  (oflow_cnt),
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int due;
        int data;
        bit sat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int pout;
        bit of;
        int off;
        int exp_data;
        bit exp_sat;
    } vec_t;
    vec_t vt[11];

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Scoreboard: each pushed record is due a fixed number of cycles after its drive.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            if (sbq[0].due == cyc) begin
                check("sb_dac_data", int'(bus.dac_data), sbq[0].data);
                check("sb_sat_flag", int'(sat_flag), int'(sbq[0].sat));
                void'(sbq.pop_front());
            end else if (sbq[0].due < cyc) begin
                check("sb_missed", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic send(input int p, input bit of, input int off,
                        input int ed, input bit es, input int prev);
        @(negedge clk);
        bus.pout      = 15'(p);
        bus.dsp_oflow = of;
        bus.fb_cond   = 1'b1;
        dac_offset    = 13'(off);
        sbq.push_back('{due: cyc + 4, data: ed, sat: es});
        @(negedge clk);
        bus.fb_cond   = 1'b0;
        bus.dsp_oflow = 1'b0;
        repeat (2) @(negedge clk);
        check("latency_hold", int'(bus.dac_data), prev);
        repeat (3) @(negedge clk);
    endtask

    task automatic wr_check(input int n);
        logic last;
        last = bus.dac_clk;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("dac_wr_follow", int'(bus.dac_wr), int'(last));
            last        = 1'($urandom_range(0, 1));
            bus.dac_clk = last;
        end
        @(negedge clk);
        check("dac_wr_follow", int'(bus.dac_wr), int'(last));
        bus.dac_clk = 1'b0;
    endtask

    initial begin
        #1500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int prev;
        bus.pout      = '0;
        bus.dsp_oflow = 1'b0;
        bus.fb_cond   = 1'b0;
        bus.dac_clk   = 1'b0;

        vt[0]  = '{1000,    0, 0,     9192,  0};
        vt[1]  = '{16383,   0, 100,   16383, 1};
        vt[2]  = '{-16384,  0, -100,  1,     1};
        vt[3]  = '{5000,    1, -20,   8172,  0};
        vt[4]  = '{-1,      0, 0,     8191,  0};
        vt[5]  = '{8191,    0, 0,     16383, 0};
        vt[6]  = '{8192,    0, 0,     16383, 1};
        vt[7]  = '{-8191,   0, 0,     1,     0};
        vt[8]  = '{0,       1, 4095,  12287, 0};
        vt[9]  = '{16383,   1, -4096, 4096,  0};
        vt[10] = '{100,     0, 0,     8292,  0};

        repeat (3) @(negedge clk);
        check("rst_dac_data", int'(bus.dac_data), MID);
        check("rst_dac_wr", int'(bus.dac_wr), 0);
        check("rst_tripped", int'(tripped), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        check("rst_oflow_cnt", int'(oflow_cnt), 0);
        check("rst_sat_cnt", int'(sat_cnt), 0);
        rst_n = 1'b1;

        wr_check(8);

        store_strb = 1'b1;
        fb_en      = 1'b1;
        repeat (3) @(negedge clk);
        check("active_not_tripped", int'(tripped), 0);

        prev = MID;
        for (int i = 0; i < 11; i++) begin
            send(vt[i].pout, vt[i].of, vt[i].off, vt[i].exp_data, vt[i].exp_sat, prev);
            prev = vt[i].exp_data;
        end
        check("table_sat_cnt", int'(sat_cnt), 3);
        check("table_oflow_cnt", int'(oflow_cnt), 3);
        check("table_not_tripped", int'(tripped), 0);

        // Three overflowed samples then a clean one must not trip.
        dac_offset = 13'sd500;
        bus.pout   = '0;
        @(negedge clk);
        bus.fb_cond   = 1'b1;
        bus.dsp_oflow = 1'b1;
        repeat (3) @(negedge clk);
        bus.dsp_oflow = 1'b0;
        @(negedge clk);
        bus.fb_cond = 1'b0;
        repeat (6) @(negedge clk);
        check("no_trip_at_3", int'(tripped), 0);
        check("offset_only_out", int'(bus.dac_data), 8692);

        // Four consecutive overflowed samples trip two cycles after the run completes.
        @(negedge clk);
        bus.fb_cond   = 1'b1;
        bus.dsp_oflow = 1'b1;
        repeat (4) @(negedge clk);
        bus.fb_cond   = 1'b0;
        bus.dsp_oflow = 1'b0;
        @(negedge clk);
        check("trip_not_early", int'(tripped), 0);
        @(negedge clk);
        check("trip_asserted", int'(tripped), 1);
        repeat (2) @(negedge clk);
        check("trip_dac_mid", int'(bus.dac_data), MID);
        check("trip_oflow_cnt", int'(oflow_cnt), 10);

        fb_en = 1'b0;
        repeat (3) @(negedge clk);
        check("trip_holds_fb_en_low", int'(tripped), 1);
        fb_en = 1'b1;
        repeat (2) @(negedge clk);
        check("trip_holds_fb_en_high", int'(tripped), 1);
        wr_check(6);

        store_strb = 1'b0;
        @(negedge clk);
        check("trip_cleared", int'(tripped), 0);
        check("idle_dac_mid", int'(bus.dac_data), MID);
        wr_check(6);

        // Counter saturation and clear priority.
        @(negedge clk);
        clr_stats     = 1'b1;
        bus.fb_cond   = 1'b1;
        bus.dsp_oflow = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        check("clr_oflow_cnt", int'(oflow_cnt), 0);
        check("clr_sat_cnt", int'(sat_cnt), 0);
        repeat (65534) @(negedge clk);
        check("oflow_cnt_65534", int'(oflow_cnt), 65534);
        @(negedge clk);
        check("oflow_cnt_65535", int'(oflow_cnt), 65535);
        repeat (4) @(negedge clk);
        check("oflow_cnt_saturated", int'(oflow_cnt), 65535);
        clr_stats = 1'b1;
        @(negedge clk);
        check("clr_priority", int'(oflow_cnt), 0);
        clr_stats = 1'b0;
        @(negedge clk);
        check("post_clr_inc", int'(oflow_cnt), 1);
        bus.fb_cond   = 1'b0;
        bus.dsp_oflow = 1'b0;

        // Reset arriving while a sample sits in the clamp stage.
        store_strb = 1'b1;
        fb_en      = 1'b1;
        dac_offset = '0;
        repeat (3) @(negedge clk);
        send(3000, 1'b0, 0, 11192, 1'b0, MID);
        @(negedge clk);
        bus.pout    = 15'sd2000;
        bus.fb_cond = 1'b1;
        @(negedge clk);
        bus.fb_cond = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_hold", int'(bus.dac_data), 11192);
        rst_n = 1'b0;
        #1;
        check("async_rst_dac_data", int'(bus.dac_data), MID);
        check("async_rst_oflow_cnt", int'(oflow_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_dac_data", int'(bus.dac_data), MID);
            check("post_rst_dac_wr", int'(bus.dac_wr), 0);
        end

        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
